// File: rtl/axil_cmd_master_pkg.sv
// Shared definitions for the AXI4-Lite command master and the sequencers that drive it.
// Contents:
//   - AXI response codes, including the local TIMEOUT code (2'b11).
//   - Control-register offsets of the sorting-network register slave.
//   - State encoding of the command master FSM.
package axil_cmd_master_pkg;

   localparam logic [1:0] RespOkay    = 2'b00;
   localparam logic [1:0] RespSlverr  = 2'b10;
   localparam logic [1:0] RespTimeout = 2'b11;

   localparam logic [31:0] RegBeat      = 32'h0000_0100;
   localparam logic [31:0] RegStart     = 32'h0000_0200;
   localparam logic [31:0] RegDone      = 32'h0000_0300;
   localparam logic [31:0] RegWriteback = 32'h0000_0400;

   typedef enum logic [2:0] {
      StIdle   = 3'd0,
      StWrReq  = 3'd1,
      StWrResp = 3'd2,
      StRdReq  = 3'd3,
      StRdResp = 3'd4,
      StRsp    = 3'd5
   } state_e;

endpackage

// File: rtl/axil_cmd_master_if.sv
// AXI4-Lite bus bundle between the command master and the register slave.
// Parameters: MADRW address width, MDATW data width (multiple of 8).
// Modports:
//   master - drives AW/W/AR channels and B/R readies.
//   slave  - drives the channel readies and the B/R responses.
interface axil_cmd_master_if #(
   parameter int unsigned MADRW = 32,
   parameter int unsigned MDATW = 32
) ();

   logic [MADRW-1:0]   awaddr;
   logic               awvalid;
   logic               awready;
   logic [MDATW-1:0]   wdata;
   logic [MDATW/8-1:0] wstrb;
   logic               wvalid;
   logic               wready;
   logic [1:0]         bresp;
   logic               bvalid;
   logic               bready;
   logic [MADRW-1:0]   araddr;
   logic               arvalid;
   logic               arready;
   logic [MDATW-1:0]   rdata;
   logic [1:0]         rresp;
   logic               rvalid;
   logic               rready;

   modport master (
      output awaddr, awvalid, input awready,
      output wdata, wstrb, wvalid, input wready,
      input bresp, bvalid, output bready,
      output araddr, arvalid, input arready,
      input rdata, rresp, rvalid, output rready
   );

   modport slave (
      input awaddr, awvalid, output awready,
      input wdata, wstrb, wvalid, output wready,
      output bresp, bvalid, input bready,
      input araddr, arvalid, output arready,
      output rdata, rresp, rvalid, input rready
   );

endinterface

// File: rtl/axil_cmd_master.sv
// Single-outstanding AXI4-Lite initiator. Accepts one command on a valid/ready stream,
// runs it as an AXI-Lite write or read and returns data plus response code on a
// valid/ready response stream. All outputs are registered.
// Ports:
//   i_clk, i_rst_n       clock, asynchronous active-low reset
//   i_cmd_*, o_cmd_ready command stream (write flag, address, data, strobes)
//   o_rsp_*, i_rsp_ready response stream (write echo, read data, resp code)
//   axi                  AXI4-Lite master modport
// Optional feature: define AXIL_CMD_MASTER_TIMEOUT_EN to enable a 16-bit watchdog that
// aborts a transaction after TIMEOUT cycles with resp 2'b11. Without it the block waits
// indefinitely for the slave.
module axil_cmd_master
   import axil_cmd_master_pkg::*;
#(
   parameter int unsigned MADRW   = 32,
   parameter int unsigned MDATW   = 32,
   parameter int unsigned TIMEOUT = 1024
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_cmd_valid,
   output logic               o_cmd_ready,
   input  logic               i_cmd_write,
   input  logic [MADRW-1:0]   i_cmd_addr,
   input  logic [MDATW-1:0]   i_cmd_wdata,
   input  logic [MDATW/8-1:0] i_cmd_wstrb,
   output logic               o_rsp_valid,
   input  logic               i_rsp_ready,
   output logic               o_rsp_write,
   output logic [MDATW-1:0]   o_rsp_rdata,
   output logic [1:0]         o_rsp_resp,
   axil_cmd_master_if.master  axi
);

   if (TIMEOUT == 0 || TIMEOUT > 65536) begin : g_bad_timeout
      $error("TIMEOUT must lie in 1..65536");
   end

   state_e             state_q;
   logic               cmd_ready_q;
   logic               rsp_valid_q;
   logic               rsp_write_q;
   logic [MDATW-1:0]   rsp_rdata_q;
   logic [1:0]         rsp_resp_q;
   logic [MADRW-1:0]   addr_q;
   logic [MDATW-1:0]   wdata_q;
   logic [MDATW/8-1:0] wstrb_q;
   logic               awvalid_q;
   logic               wvalid_q;
   logic               bready_q;
   logic               arvalid_q;
   logic               rready_q;
   logic               step_done;

   // The current wait state completes on this edge.
   always_comb begin
      step_done = 1'b0;
      case (state_q)
         // AW and W retire independently; a channel already retired counts as done.
         StWrReq:  step_done = (axi.awready || !awvalid_q) && (axi.wready || !wvalid_q);
         StWrResp: step_done = axi.bvalid;
         StRdReq:  step_done = axi.arready;
         StRdResp: step_done = axi.rvalid;
         default:  step_done = 1'b0;
      endcase
   end

`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
   logic [15:0] wd_q;
   logic        wait_st;
   logic        wd_expired;

   assign wait_st    = (state_q == StWrReq) || (state_q == StWrResp) ||
                       (state_q == StRdReq) || (state_q == StRdResp);
   assign wd_expired = wait_st && !step_done && (wd_q == 16'(TIMEOUT - 1));

   // Held at zero in IDLE so it starts from zero when a request state is entered.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wd_q <= '0;
      end else if (state_q == StIdle) begin
         wd_q <= '0;
      end else if (wait_st) begin
         wd_q <= wd_q + 16'd1;
      end
   end
`endif

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q     <= StIdle;
         cmd_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_write_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_resp_q  <= RespOkay;
         addr_q      <= '0;
         wdata_q     <= '0;
         wstrb_q     <= '0;
         awvalid_q   <= 1'b0;
         wvalid_q    <= 1'b0;
         bready_q    <= 1'b0;
         arvalid_q   <= 1'b0;
         rready_q    <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (cmd_ready_q && i_cmd_valid) begin
                  cmd_ready_q <= 1'b0;
                  addr_q      <= i_cmd_addr;
                  wdata_q     <= i_cmd_wdata;
                  wstrb_q     <= i_cmd_wstrb;
                  rsp_write_q <= i_cmd_write;
                  if (i_cmd_write) begin
                     awvalid_q <= 1'b1;
                     wvalid_q  <= 1'b1;
                     state_q   <= StWrReq;
                  end else begin
                     arvalid_q <= 1'b1;
                     state_q   <= StRdReq;
                  end
               end else begin
                  // Ready rises one cycle after entering IDLE, also after reset release.
                  cmd_ready_q <= 1'b1;
               end
            end
            StWrReq: begin
               if (axi.awready) awvalid_q <= 1'b0;
               if (axi.wready)  wvalid_q  <= 1'b0;
               if (step_done) begin
                  bready_q <= 1'b1;
                  state_q  <= StWrResp;
               end
            end
            StWrResp: begin
               if (step_done) begin
                  rsp_resp_q  <= axi.bresp;
                  rsp_rdata_q <= '0;
                  bready_q    <= 1'b0;
                  rsp_valid_q <= 1'b1;
                  state_q     <= StRsp;
               end
            end
            StRdReq: begin
               if (step_done) begin
                  arvalid_q <= 1'b0;
                  rready_q  <= 1'b1;
                  state_q   <= StRdResp;
               end
            end
            StRdResp: begin
               if (step_done) begin
                  rsp_resp_q  <= axi.rresp;
                  rsp_rdata_q <= axi.rdata;
                  rready_q    <= 1'b0;
                  rsp_valid_q <= 1'b1;
                  state_q     <= StRsp;
               end
            end
            StRsp: begin
               if (i_rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  state_q     <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase

`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
         // Later assignments override the case above for this edge.
         if (wd_expired) begin
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            bready_q    <= 1'b0;
            rready_q    <= 1'b0;
            rsp_resp_q  <= RespTimeout;
            rsp_rdata_q <= '0;
            rsp_valid_q <= 1'b1;
            state_q     <= StRsp;
         end
`endif
      end
   end

   assign o_cmd_ready = cmd_ready_q;
   assign o_rsp_valid = rsp_valid_q;
   assign o_rsp_write = rsp_write_q;
   assign o_rsp_rdata = rsp_rdata_q;
   assign o_rsp_resp  = rsp_resp_q;
   assign axi.awaddr  = addr_q;
   assign axi.araddr  = addr_q;
   assign axi.wdata   = wdata_q;
   assign axi.wstrb   = wstrb_q;
   assign axi.awvalid = awvalid_q;
   assign axi.wvalid  = wvalid_q;
   assign axi.bready  = bready_q;
   assign axi.arvalid = arvalid_q;
   assign axi.rready  = rready_q;

endmodule

// File: tb/tb_axil_cmd_master.sv
// Bench for axil_cmd_master: a table of directed transactions with hand-derived results,
// hand-written reset/timeout sequences, and random transactions checked against an
// address-map model. The bench plays the AXI-Lite slave: offsets with addr[3:2]==01
// answer SLVERR (reads return 0xEEEEEEEE, writes are dropped), addr[3:2]==10 answer
// resp 01 with normal data, everything else is OKAY storage.
module tb_axil_cmd_master;
   import axil_cmd_master_pkg::*;

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
      int          a_dly;
      int          w_dly;
      int          r_dly;
      int          rsp_dly;
      logic [1:0]  exp_resp;
      logic [31:0] exp_rdata;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_write = 1'b0;
   logic [31:0] cmd_addr = '0;
   logic [31:0] cmd_wdata = '0;
   logic [3:0]  cmd_wstrb = '0;
   logic        rsp_ready = 1'b0;
   logic        o_cmd_ready;
   logic        o_rsp_valid;
   logic        o_rsp_write;
   logic [31:0] o_rsp_rdata;
   logic [1:0]  o_rsp_resp;

   int n_checks = 0;
   int n_pass = 0;

   logic [31:0] ref_mem [logic [31:0]];
   logic [31:0] slv_mem [logic [31:0]];

   always #5 clk = ~clk;

   axil_cmd_master_if #(.MADRW(32), .MDATW(32)) axi ();

   axil_cmd_master #(.MADRW(32), .MDATW(32), .TIMEOUT(16)) u_dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_cmd_valid (cmd_valid),
      .o_cmd_ready (o_cmd_ready),
      .i_cmd_write (cmd_write),
      .i_cmd_addr  (cmd_addr),
      .i_cmd_wdata (cmd_wdata),
      .i_cmd_wstrb (cmd_wstrb),
      .o_rsp_valid (o_rsp_valid),
      .i_rsp_ready (rsp_ready),
      .o_rsp_write (o_rsp_write),
      .o_rsp_rdata (o_rsp_rdata),
      .o_rsp_resp  (o_rsp_resp),
      .axi         (axi.master)
   );

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, got, exp);
   endtask

   function automatic logic any_out();
      return |{o_cmd_ready, o_rsp_valid, o_rsp_write, o_rsp_resp, o_rsp_rdata,
               axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready,
               axi.awaddr, axi.araddr, axi.wdata, axi.wstrb};
   endfunction

   // Address-map model: what a command should return, computed from the command alone.
   function automatic void model(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                                 input logic [3:0] strb, output logic [1:0] resp,
                                 output logic [31:0] rdata);
      logic [31:0] cur;
      cur   = ref_mem.exists(addr) ? ref_mem[addr] : 32'h0;
      resp  = (addr[3:2] == 2'b01) ? 2'b10 : (addr[3:2] == 2'b10) ? 2'b01 : 2'b00;
      rdata = 32'h0;
      if (wr) begin
         if (resp != 2'b10) begin
            for (int b = 0; b < 4; b++) if (strb[b]) cur[8*b +: 8] = data[8*b +: 8];
            ref_mem[addr] = cur;
         end
      end else begin
         rdata = (resp == 2'b10) ? 32'hEEEE_EEEE : cur;
      end
   endfunction

   // Slave side: acts only on what was captured from the bus.
   function automatic void slave_write(input logic [31:0] a, input logic [31:0] d,
                                       input logic [3:0] s, output logic [1:0] resp);
      logic [31:0] cur;
      cur  = slv_mem.exists(a) ? slv_mem[a] : 32'h0;
      resp = (a[3:2] == 2'b01) ? 2'b10 : (a[3:2] == 2'b10) ? 2'b01 : 2'b00;
      if (resp != 2'b10) begin
         for (int b = 0; b < 4; b++) if (s[b]) cur[8*b +: 8] = d[8*b +: 8];
         slv_mem[a] = cur;
      end
   endfunction

   function automatic void slave_read(input logic [31:0] a, output logic [31:0] d,
                                      output logic [1:0] resp);
      resp = (a[3:2] == 2'b01) ? 2'b10 : (a[3:2] == 2'b10) ? 2'b01 : 2'b00;
      d    = (resp == 2'b10) ? 32'hEEEE_EEEE : (slv_mem.exists(a) ? slv_mem[a] : 32'h0);
   endfunction

   task automatic slave_idle();
      axi.awready = 1'b0;
      axi.wready  = 1'b0;
      axi.bvalid  = 1'b0;
      axi.bresp   = 2'b00;
      axi.arready = 1'b0;
      axi.rvalid  = 1'b0;
      axi.rresp   = 2'b00;
      axi.rdata   = '0;
   endtask

   task automatic wait_cmd_ready(input string name);
      int n = 0;
      while (!o_cmd_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      check(name, o_cmd_ready, 1);
   endtask

   // One full transaction; the bus is observed and driven on negedges, so a ready/valid
   // pair seen at a negedge completes on the following posedge.
   task automatic run_txn(input vec_t v, input logic [1:0] exp_resp, input logic [31:0] exp_rdata);
      int since;
      int a_n;
      int w_n;
      int r_n;
      bit ok;
      bit a_hs;
      bit w_hs;
      bit r_hs;
      bit stored;
      logic [31:0] cap_addr;
      logic [31:0] cap_data;
      logic [3:0]  cap_strb;
      logic [31:0] slv_rdata;
      logic [1:0]  slv_resp;
      logic        rw;
      logic [1:0]  rr;
      logic [31:0] rd;
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_write = v.wr;
      cmd_addr  = v.addr;
      cmd_wdata = v.data;
      cmd_wstrb = v.strb;
      wait_cmd_ready("cmd_accept");
      if (!o_cmd_ready) begin
         cmd_valid = 1'b0;
         return;
      end
      @(negedge clk);
      // Scramble the command bus so only captured values can reach AXI.
      cmd_valid = 1'b0;
      cmd_write = ~v.wr;
      cmd_addr  = $urandom;
      cmd_wdata = $urandom;
      cmd_wstrb = 4'($urandom);
      check("req_start", {o_cmd_ready, axi.awvalid, axi.wvalid, axi.arvalid},
            v.wr ? 4'b0110 : 4'b0001);
      since = 0; a_n = 0; w_n = 0; r_n = 0;
      ok = 1; a_hs = 0; w_hs = 0; r_hs = 0; stored = 0;
      slv_resp = 2'b00; slv_rdata = '0; cap_addr = '0; cap_data = '0; cap_strb = '0;
      while (!r_hs && since < 100) begin
         ok &= !o_cmd_ready && !o_rsp_valid;
         if (v.wr) begin
            ok &= !axi.arvalid && !axi.rready;
            if (!a_hs) ok &= axi.awvalid && (axi.awaddr == v.addr);
            else       ok &= !axi.awvalid;
            if (!w_hs) ok &= axi.wvalid && (axi.wdata == v.data) && (axi.wstrb == v.strb);
            else       ok &= !axi.wvalid;
            ok &= (axi.bready == (a_hs && w_hs));
            axi.awready = !a_hs && (a_n >= v.a_dly);
            axi.wready  = !w_hs && (w_n >= v.w_dly);
            axi.bvalid  = a_hs && w_hs && (r_n >= v.r_dly);
            axi.bresp   = axi.bvalid ? slv_resp : 2'($urandom);
            if (a_hs && w_hs) r_n++;
            if (!a_hs) a_n++;
            if (!w_hs) w_n++;
            if (axi.bvalid && axi.bready) r_hs = 1;
            if (axi.awready && axi.awvalid) begin
               a_hs = 1;
               cap_addr = axi.awaddr;
            end
            if (axi.wready && axi.wvalid) begin
               w_hs = 1;
               cap_data = axi.wdata;
               cap_strb = axi.wstrb;
            end
            if (a_hs && w_hs && !stored) begin
               slave_write(cap_addr, cap_data, cap_strb, slv_resp);
               stored = 1;
            end
         end else begin
            ok &= !axi.awvalid && !axi.wvalid && !axi.bready;
            if (!a_hs) ok &= axi.arvalid && (axi.araddr == v.addr);
            else       ok &= !axi.arvalid;
            ok &= (axi.rready == a_hs);
            axi.arready = !a_hs && (a_n >= v.a_dly);
            axi.rvalid  = a_hs && (r_n >= v.r_dly);
            axi.rresp   = axi.rvalid ? slv_resp : 2'($urandom);
            axi.rdata   = axi.rvalid ? slv_rdata : $urandom;
            if (a_hs) r_n++;
            else      a_n++;
            if (axi.rvalid && axi.rready) r_hs = 1;
            if (axi.arready && axi.arvalid) begin
               a_hs = 1;
               slave_read(axi.araddr, slv_rdata, slv_resp);
            end
         end
         @(negedge clk);
         since++;
      end
      slave_idle();
      check("bus_protocol", ok, 1);
      check("resp_handshake", r_hs, 1);
      check("rsp_valid", {o_rsp_valid, axi.bready, axi.rready}, 3'b100);
      rw = o_rsp_write;
      rr = o_rsp_resp;
      rd = o_rsp_rdata;
      ok = 1;
      for (int i = 0; i < v.rsp_dly; i++) begin
         rsp_ready = 1'b0;
         @(negedge clk);
         since++;
         ok &= o_rsp_valid && !o_cmd_ready && (o_rsp_write == rw) && (o_rsp_resp == rr) &&
               (o_rsp_rdata == rd);
      end
      check("rsp_stable", ok, 1);
      check("rsp_write", rw, v.wr);
      check("rsp_resp", rr, exp_resp);
      check("rsp_rdata", rd, exp_rdata);
      rsp_ready = 1'b1;
      @(negedge clk);
      since++;
      rsp_ready = 1'b0;
      check("rsp_drop", o_rsp_valid, 0);
      while (!o_cmd_ready && since < 200) begin
         @(negedge clk);
         since++;
      end
      check("b2b_gap_ge4", (since >= 4) && o_cmd_ready, 1);
   endtask

   vec_t tbl [13];
   vec_t v;
   logic [1:0]  m_resp;
   logic [31:0] m_rdata;
   logic [31:0] addrs [7];

   initial begin
      #500000;
      $display("FAIL global_timeout: got stuck expected finish");
      $fatal(1, "bench watchdog");
   end

   initial begin
      slave_idle();
      ref_mem[RegDone] = 32'h1;
      slv_mem[RegDone] = 32'h1;
      //           wr    addr          data          strb     a  w  r  rsp  resp   rdata
      tbl[0]  = '{1'b1, RegBeat,      32'h40,        4'hF,    0, 0, 0, 0, 2'b00, 32'h0};
      tbl[1]  = '{1'b0, RegBeat,      32'h0,         4'h0,    0, 0, 0, 0, 2'b00, 32'h40};
      tbl[2]  = '{1'b1, RegStart,     32'h1,         4'hF,    0, 3, 0, 0, 2'b00, 32'h0};
      tbl[3]  = '{1'b0, RegDone,      32'h0,         4'h0,    0, 0, 0, 0, 2'b00, 32'h1};
      tbl[4]  = '{1'b0, 32'h204,      32'h0,         4'h0,    0, 0, 1, 0, 2'b10, 32'hEEEE_EEEE};
      tbl[5]  = '{1'b1, 32'h204,      32'hDEAD_BEEF, 4'hF,    0, 0, 0, 0, 2'b10, 32'h0};
      tbl[6]  = '{1'b1, RegWriteback, 32'hAABB_CCDD, 4'b0101, 1, 1, 1, 0, 2'b00, 32'h0};
      tbl[7]  = '{1'b0, RegWriteback, 32'h0,         4'h0,    0, 0, 0, 0, 2'b00, 32'h00BB_00DD};
      tbl[8]  = '{1'b0, RegBeat,      32'h0,         4'h0,    2, 0, 3, 5, 2'b00, 32'h40};
      tbl[9]  = '{1'b0, 32'h208,      32'h0,         4'h0,    0, 0, 0, 0, 2'b01, 32'h0};
      tbl[10] = '{1'b1, RegBeat,      32'h1122_3344, 4'b1100, 2, 0, 4, 0, 2'b00, 32'h0};
      tbl[11] = '{1'b0, RegBeat,      32'h0,         4'h0,    0, 0, 0, 0, 2'b00, 32'h1122_0040};
      tbl[12] = '{1'b0, RegStart,     32'h0,         4'h0,    0, 0, 0, 1, 2'b00, 32'h1};
      addrs = '{RegBeat, RegStart, RegDone, RegWriteback, 32'h204, 32'h208, 32'h10C};

      // Reset state.
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_outputs", any_out(), 0);
      rst_n = 1'b1;
      @(negedge clk);
      check("cmd_ready_after_reset", o_cmd_ready, 1);

      foreach (tbl[i]) begin
         model(tbl[i].wr, tbl[i].addr, tbl[i].data, tbl[i].strb, m_resp, m_rdata);
         run_txn(tbl[i], tbl[i].exp_resp, tbl[i].exp_rdata);
      end

      // Reset while waiting for B.
      @(negedge clk);
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h10C;
      cmd_wdata = 32'h1234_5678; cmd_wstrb = 4'hF;
      wait_cmd_ready("rst_cmd_accept");
      @(negedge clk);
      cmd_valid = 1'b0;
      axi.awready = 1'b1; axi.wready = 1'b1;
      @(negedge clk);
      axi.awready = 1'b0; axi.wready = 1'b0;
      slave_write(32'h10C, 32'h1234_5678, 4'hF, m_resp);
      model(1'b1, 32'h10C, 32'h1234_5678, 4'hF, m_resp, m_rdata);
      check("rst_pre_bready", {axi.bready, o_rsp_valid}, 2'b10);
      #2 rst_n = 1'b0;
      #1 check("rst_async_clear", any_out(), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      v = '{1'b1, 32'h10C, 32'hCAFE_F00D, 4'hF, 0, 0, 0, 0, 2'b00, 32'h0};
      model(v.wr, v.addr, v.data, v.strb, m_resp, m_rdata);
      run_txn(v, v.exp_resp, v.exp_rdata);
      v = '{1'b0, 32'h10C, 32'h0, 4'h0, 1, 0, 2, 0, 2'b00, 32'hCAFE_F00D};
      model(v.wr, v.addr, v.data, v.strb, m_resp, m_rdata);
      run_txn(v, v.exp_resp, v.exp_rdata);

      // Random traffic against the model.
      for (int i = 0; i < 40; i++) begin
         v.wr      = 1'($urandom_range(0, 1));
         v.addr    = addrs[$urandom_range(0, 6)];
         v.data    = $urandom;
         v.strb    = 4'($urandom_range(0, 15));
         v.a_dly   = int'($urandom_range(0, 3));
         v.w_dly   = int'($urandom_range(0, 3));
         v.r_dly   = int'($urandom_range(0, 3));
         v.rsp_dly = int'($urandom_range(0, 2));
         model(v.wr, v.addr, v.data, v.strb, m_resp, m_rdata);
         run_txn(v, m_resp, m_rdata);
      end

`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
      begin : timeout_seq
         int n;
         bit ok;
         @(negedge clk);
         cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = RegBeat;
         cmd_wdata = 32'h55; cmd_wstrb = 4'hF;
         wait_cmd_ready("to_cmd_accept");
         @(negedge clk);
         cmd_valid = 1'b0;
         axi.awready = 1'b1; axi.wready = 1'b1;
         @(negedge clk);
         axi.awready = 1'b0; axi.wready = 1'b0;
         n = 1;
         while (!o_rsp_valid && n < 40) begin
            @(negedge clk);
            n++;
         end
         check("to_latency", n, 16);
         check("to_rsp", {o_rsp_write, o_rsp_resp, o_rsp_rdata, axi.bready},
               {1'b1, 2'b11, 32'h0, 1'b0});
         ok = 1;
         axi.bvalid = 1'b1; axi.bresp = 2'b00;
         for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            ok &= !axi.bready && o_rsp_valid && (o_rsp_resp == 2'b11);
         end
         axi.bvalid = 1'b0;
         check("to_late_b_ignored", ok, 1);
         rsp_ready = 1'b1;
         @(negedge clk);
         rsp_ready = 1'b0;
         check("to_rsp_drop", o_rsp_valid, 0);
         rst_n = 1'b0;
         @(negedge clk);
         rst_n = 1'b1;
      end
`endif

      @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
